// File: rtl/ysyx_23060025_fetch.sv
// Instruction fetch unit: holds the PC, issues one icache fetch at a time,
// buffers the returned word for the IDU and sequences redirects / fence.i.
module ysyx_23060025_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] out_paddr,
  output logic                  out_psel,
  input  logic                  in_pready,
  input  logic [31:0]           in_prdata,
  output logic                  out_fence_flag,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  in_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] in_redirect_pc,
  input  logic                  in_fence_i
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FENCE = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic                  pend_redir, pend_redir_n;
  logic [ADDR_WIDTH-1:0] pend_pc, pend_pc_n;
  logic                  pend_fence, pend_fence_n;
  logic [31:0]           inst_n;
  logic [ADDR_WIDTH-1:0] pc_r_n;
  logic                  valid_n;
  logic                  fence_n;
  logic [ADDR_WIDTH-1:0] redir_tgt;
  logic                  redir_fence;

  // Redirect targets are always word aligned.
  assign redir_tgt   = in_redirect_pc & ~ADDR_WIDTH'(3);
  assign redir_fence = in_redirect_valid & in_fence_i;

  // Request is dropped in the pready cycle so the icache never sees a stale address.
  assign out_psel  = (state == S_FETCH) && !in_pready && !reset;
  assign out_paddr = pc;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_FETCH;
      pc             <= RESET_PC;
      pend_redir     <= 1'b0;
      pend_pc        <= RESET_PC;
      pend_fence     <= 1'b0;
      out_valid      <= 1'b0;
      out_fence_flag <= 1'b0;
      out_inst       <= 32'h0;
      out_pc         <= RESET_PC;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      pend_redir     <= pend_redir_n;
      pend_pc        <= pend_pc_n;
      pend_fence     <= pend_fence_n;
      out_valid      <= valid_n;
      out_fence_flag <= fence_n;
      out_inst       <= inst_n;
      out_pc         <= pc_r_n;
    end
  end

  // Next-state and next-register logic; pc only moves when no fetch is outstanding.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pend_redir_n = pend_redir;
    pend_pc_n    = pend_pc;
    pend_fence_n = pend_fence;
    inst_n       = out_inst;
    pc_r_n       = out_pc;
    valid_n      = 1'b0;
    fence_n      = 1'b0;
    case (state)
      S_FETCH: begin
        if (in_pready) begin
          if (pend_redir || in_redirect_valid) begin
            // Returned word belongs to the old path: drop it and retarget.
            pc_n         = in_redirect_valid ? redir_tgt : pend_pc;
            pend_redir_n = 1'b0;
            pend_fence_n = 1'b0;
            if (pend_fence || redir_fence) begin
              state_n = S_FENCE;
              fence_n = 1'b1;
            end
          end else begin
            inst_n  = in_prdata;
            pc_r_n  = pc;
            valid_n = 1'b1;
            state_n = S_HOLD;
          end
        end else if (in_redirect_valid) begin
          pend_redir_n = 1'b1;
          pend_pc_n    = redir_tgt;
          pend_fence_n = pend_fence | in_fence_i;
        end
      end
      S_HOLD: begin
        if (in_redirect_valid) begin
          pc_n = redir_tgt;
          if (in_fence_i) begin
            state_n = S_FENCE;
            fence_n = 1'b1;
          end else begin
            state_n = S_FETCH;
          end
        end else if (in_ready) begin
          pc_n    = pc + ADDR_WIDTH'(4);
          state_n = S_FETCH;
        end else begin
          valid_n = 1'b1;
        end
      end
      S_FENCE: begin
        if (in_redirect_valid) begin
          pc_n = redir_tgt;
        end
        state_n = S_FETCH;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_fetch.sv
// Bench for the fetch unit: icache/IDU models, transaction-level reference
// (architectural PC stream), directed corner sequences and random traffic.
module tb_ysyx_23060025_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock;
  logic        reset;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        out_fence_flag;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        in_redirect_valid;
  logic [31:0] in_redirect_pc;
  logic        in_fence_i;

  ysyx_23060025_fetch dut (
    .clock             (clock),
    .reset             (reset),
    .out_paddr         (out_paddr),
    .out_psel          (out_psel),
    .in_pready         (in_pready),
    .in_prdata         (in_prdata),
    .out_fence_flag    (out_fence_flag),
    .out_valid         (out_valid),
    .in_ready          (in_ready),
    .out_inst          (out_inst),
    .out_pc            (out_pc),
    .in_redirect_valid (in_redirect_valid),
    .in_redirect_pc    (in_redirect_pc),
    .in_fence_i        (in_fence_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Stimulus knobs set by the directed/random sections.
  logic        drv_reset = 1'b1;
  logic        drv_ready = 1'b0;
  logic        drv_redir = 1'b0;
  logic [31:0] drv_rpc   = 32'h0;
  logic        drv_fence = 1'b0;
  bit          rand_lat  = 1'b0;

  // icache model state.
  bit          ic_busy = 1'b0;
  int          ic_cnt  = 0;
  logic [31:0] ic_addr = 32'h0;

  // Reference model: the architectural PC the next accepted instruction must carry.
  logic [31:0] model_pc   = RST_PC;
  bit          fence_owed = 1'b0;
  int          fence_cnt  = 0;
  int          psel_cnt   = 0;
  int          hs_cnt     = 0;
  int          last_pready_cyc = 0;
  logic [31:0] last_psel_addr  = 32'h0;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_inst = 32'h0;
  logic [31:0] prev_pc   = 32'h0;

  typedef struct {
    logic [31:0] target;
    logic        fence;
    logic [31:0] exp_addr;
    int          exp_fences;
  } vec_t;
  vec_t tbl [4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0000_0413;
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // One clock cycle: drive inputs, run icache model and reference checks, advance.
  task automatic step();
    bit hs;
    reset             = drv_reset;
    in_pready         = !drv_reset && ic_busy && (ic_cnt == 0);
    in_prdata         = in_pready ? mem_word(ic_addr) : 32'hDEAD_BEEF;
    in_ready          = drv_ready;
    in_redirect_valid = drv_redir;
    in_redirect_pc    = drv_rpc;
    in_fence_i        = drv_fence;
    #1;
    if (drv_reset) begin
      check("psel_in_reset", 32'(out_psel), 32'h0);
      ic_busy    = 1'b0;
      model_pc   = RST_PC;
      fence_owed = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      check("psel_and_pready", 32'(out_psel & in_pready), 32'h0);
      if (out_fence_flag) begin
        check("fence_with_psel", 32'(out_psel), 32'h0);
        check("fence_icache_busy", 32'(ic_busy), 32'h0);
        fence_owed = 1'b0;
        fence_cnt++;
      end
      if (hold_prev) begin
        check("valid_held", 32'(out_valid), 32'h1);
        check("inst_held", out_inst, prev_inst);
        check("pc_held", out_pc, prev_pc);
      end
      if (ic_busy) begin
        check("paddr_stable", out_paddr, ic_addr);
        if (in_pready) begin
          ic_busy = 1'b0;
          last_pready_cyc = cyc;
        end else begin
          ic_cnt--;
        end
      end else if (out_psel) begin
        ic_busy        = 1'b1;
        ic_addr        = out_paddr;
        ic_cnt         = rand_lat ? int'($urandom_range(0, 2)) : 1;
        last_psel_addr = out_paddr;
        psel_cnt++;
      end
      hs = out_valid && in_ready && !in_redirect_valid;
      if (hs) begin
        check("hs_pc", out_pc, model_pc);
        check("hs_inst", out_inst, mem_word(model_pc));
        check("hs_fence_done", 32'(fence_owed), 32'h0);
        model_pc = model_pc + 32'd4;
        hs_cnt++;
      end
      if (in_redirect_valid) begin
        model_pc = in_redirect_pc & ~32'd3;
        if (in_fence_i) fence_owed = 1'b1;
      end
      hold_prev = out_valid && !hs && !in_redirect_valid;
      prev_inst = out_inst;
      prev_pc   = out_pc;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!out_valid && k < max) begin
      step();
      k++;
    end
    if (!out_valid) timeout("wait_valid");
  endtask

  task automatic wait_psel(input int max);
    int p0 = psel_cnt;
    int k  = 0;
    while (psel_cnt == p0 && k < max) begin
      step();
      k++;
    end
    if (psel_cnt == p0) timeout("wait_psel");
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic fence);
    drv_redir = 1'b1;
    drv_rpc   = tgt;
    drv_fence = fence;
    step();
    drv_redir = 1'b0;
    drv_fence = 1'b0;
  endtask

  initial begin
    int fc0;
    int p0;
    int h0;
    int last_hs;
    int last_hs_cyc;
    logic [31:0] r;

    tbl[0] = '{32'h8000_0203, 1'b0, 32'h8000_0200, 0};
    tbl[1] = '{32'h1234_5677, 1'b1, 32'h1234_5674, 1};
    tbl[2] = '{32'h0000_0001, 1'b0, 32'h0000_0000, 0};
    tbl[3] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 0};

    reset = 1'b1; in_pready = 1'b0; in_prdata = 32'h0; in_ready = 1'b0;
    in_redirect_valid = 1'b0; in_redirect_pc = 32'h0; in_fence_i = 1'b0;
    @(posedge clock);
    #1;
    step();
    step();

    // Reset state.
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_fence", 32'(out_fence_flag), 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, RST_PC);
    check("rst_paddr", out_paddr, RST_PC);

    // First fetch: pready two cycles after psel, valid one cycle after pready.
    drv_reset = 1'b0;
    drv_ready = 1'b1;
    wait_psel(5);
    check("t1_paddr", last_psel_addr, RST_PC);
    wait_valid(10);
    check("t1_latency", 32'(cyc - last_pready_cyc), 32'd1);
    check("t1_inst", out_inst, 32'h0000_0413);
    check("t1_pc", out_pc, RST_PC);
    step();
    wait_psel(5);
    check("t1_next_paddr", last_psel_addr, 32'h8000_0004);

    // Stall the IDU for five cycles.
    drv_ready = 1'b0;
    wait_valid(10);
    check("t2_pc", out_pc, 32'h8000_0004);
    p0 = psel_cnt;
    for (int i = 0; i < 5; i++) step();
    check("t2_no_psel", 32'(psel_cnt - p0), 32'h0);
    check("t2_paddr", out_paddr, 32'h8000_0004);
    check("t2_valid", 32'(out_valid), 32'h1);
    check("t2_inst", out_inst, mem_word(32'h8000_0004));
    drv_ready = 1'b1;
    step();
    drv_ready = 1'b0;

    // Redirect while a fetch is outstanding.
    wait_psel(5);
    h0 = hs_cnt;
    redirect(32'h8000_0100, 1'b0);
    wait_psel(10);
    check("t3_paddr", last_psel_addr, 32'h8000_0100);
    check("t3_no_stale_valid", 32'(hs_cnt - h0), 32'h0);
    wait_valid(10);
    check("t3_pc", out_pc, 32'h8000_0100);

    // Redirect with fence.i from the hold state.
    fc0 = fence_cnt;
    redirect(32'h8000_0010, 1'b1);
    check("t4_valid_drop", 32'(out_valid), 32'h0);
    check("t4_fence_flag", 32'(out_fence_flag), 32'h1);
    check("t4_fence_psel", 32'(out_psel), 32'h0);
    wait_psel(10);
    check("t4_paddr", last_psel_addr, 32'h8000_0010);
    check("t4_fences", 32'(fence_cnt - fc0), 32'd1);

    // Redirect alignment and targets from the table.
    for (int i = 0; i < 4; i++) begin
      wait_valid(10);
      fc0 = fence_cnt;
      redirect(tbl[i].target, tbl[i].fence);
      check("t5_valid_drop", 32'(out_valid), 32'h0);
      wait_psel(10);
      check("t5_paddr", last_psel_addr, tbl[i].exp_addr);
      check("t5_fences", 32'(fence_cnt - fc0), 32'(tbl[i].exp_fences));
    end

    // PC wrap past the top of the address space.
    wait_valid(10);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    drv_ready = 1'b1;
    step();
    drv_ready = 1'b0;
    wait_psel(5);
    check("wrap_paddr", last_psel_addr, 32'h0000_0000);

    // Reset in the middle of an outstanding fetch.
    drv_reset = 1'b1;
    step();
    drv_reset = 1'b0;
    check("midrst_paddr", out_paddr, RST_PC);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_fence", 32'(out_fence_flag), 32'h0);
    wait_psel(5);
    check("midrst_psel_addr", last_psel_addr, RST_PC);

    // Random traffic against the reference model.
    rand_lat    = 1'b1;
    last_hs     = hs_cnt;
    last_hs_cyc = cyc;
    for (int i = 0; i < 3000; i++) begin
      drv_ready = ($urandom_range(0, 3) != 0);
      drv_redir = !out_fence_flag && ($urandom_range(0, 15) == 0);
      r         = $urandom;
      drv_rpc   = {1'b1, 21'h0, r[9:0]};
      drv_fence = drv_redir && ($urandom_range(0, 2) == 0);
      step();
      if (hs_cnt != last_hs) begin
        last_hs     = hs_cnt;
        last_hs_cyc = cyc;
      end else if (cyc - last_hs_cyc > 200) begin
        timeout("random_progress");
        break;
      end
    end
    drv_redir = 1'b0;
    drv_fence = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
